// File: rtl/mem_stage.sv
// Memory-access stage: dcache request/response handshake, store lane alignment,
// load extraction and the MEM/WB register. Optional macro: MEM_MISALIGN_TRAP_EN.
// exmem_ctrl_word layout: [0] mem_read, [1] mem_write, [7:2] carried to writeback.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exmem_valid,
  input  logic [31:0] exmem_instruction,
  input  logic [7:0]  exmem_ctrl_word,
  input  logic [31:0] exmem_alu_out,
  input  logic        exmem_br_en,
  input  logic [31:0] exmem_rs2_out,
  input  logic [31:0] exmem_pc,
  input  logic        ext_stall,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic        misalign,
  output logic        memwb_valid,
  output logic [31:0] memwb_instruction,
  output logic [7:0]  memwb_ctrl_word,
  output logic [31:0] memwb_alu_out,
  output logic        memwb_br_en,
  output logic [31:0] memwb_pc,
  output logic [31:0] memwb_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, next_state;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        mem_read, mem_write, mem_op, misaligned, req;
  logic [31:0] held_rdata, src_rdata, load_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        unused_bits;

  assign funct3    = exmem_instruction[14:12];
  assign off       = exmem_alu_out[1:0];
  assign mem_read  = exmem_ctrl_word[0];
  assign mem_write = exmem_ctrl_word[1];
  assign mem_op    = mem_read | mem_write;

  assign misaligned = mem_op & (((funct3[1:0] == 2'b01) && (off == 2'b11)) ||
                                ((funct3[1:0] == 2'b10) && (off != 2'b00)));

  assign req        = rst & exmem_valid & mem_op & ~misaligned & (state != DONE);
  assign dmem_read  = req & mem_read;
  assign dmem_write = req & mem_write;
  assign mem_stall  = req & ~dmem_resp;

  assign dmem_address = {exmem_alu_out[31:2], 2'b00};
  assign unused_bits  = ^{exmem_instruction[31:15], exmem_instruction[11:0]};

  always_comb begin
    dmem_mbe   = 4'b1111;
    dmem_wdata = exmem_rs2_out << {off, 3'b000};
    if (mem_write) begin
      case (funct3[1:0])
        2'b00:   dmem_mbe = 4'b0001 << off;
        2'b01:   dmem_mbe = 4'b0011 << off;
        default: begin
          dmem_mbe   = 4'b1111;
          dmem_wdata = exmem_rs2_out;
        end
      endcase
    end
  end

  // Once the response is parked in DONE, extraction reads the held copy.
  assign src_rdata = (state == DONE) ? held_rdata : dmem_rdata;
  assign sel_byte  = 8'(src_rdata >> {off, 3'b000});
  assign sel_half  = off[1] ? src_rdata[31:16] : src_rdata[15:0];

  always_comb begin
    load_data = '0;
    if (mem_read && !misaligned) begin
      case (funct3)
        3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
        3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
        3'b100:  load_data = {24'h0, sel_byte};
        3'b101:  load_data = {16'h0, sel_half};
        default: load_data = src_rdata;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) begin
        if (!dmem_resp)     next_state = WAIT;
        else if (ext_stall) next_state = DONE;
      end
      WAIT: if (dmem_resp)  next_state = ext_stall ? DONE : IDLE;
      DONE: if (!ext_stall) next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      held_rdata        <= '0;
      memwb_valid       <= 1'b0;
      memwb_instruction <= '0;
      memwb_ctrl_word   <= '0;
      memwb_alu_out     <= '0;
      memwb_br_en       <= 1'b0;
      memwb_pc          <= '0;
      memwb_rdata       <= '0;
    end else begin
      state <= next_state;
      if (next_state == DONE && state != DONE)
        held_rdata <= dmem_rdata;
      if (!ext_stall) begin
        if (mem_stall) begin
          memwb_valid <= 1'b0;
        end else begin
          memwb_valid       <= exmem_valid;
          memwb_instruction <= exmem_instruction;
          memwb_ctrl_word   <= exmem_ctrl_word;
          memwb_alu_out     <= exmem_alu_out;
          memwb_br_en       <= exmem_br_en;
          memwb_pc          <= exmem_pc;
          memwb_rdata       <= load_data;
        end
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst)
      misalign <= 1'b0;
    else if (!ext_stall)
      misalign <= ~mem_stall & exmem_valid & misaligned;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a queue of expected MEM/WB results.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exmem_valid = 1'b0;
  logic [31:0] exmem_instruction = '0;
  logic [7:0]  exmem_ctrl_word = '0;
  logic [31:0] exmem_alu_out = '0;
  logic        exmem_br_en = 1'b0;
  logic [31:0] exmem_rs2_out = '0;
  logic [31:0] exmem_pc = '0;
  logic        ext_stall = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_resp = 1'b0;
  logic        dmem_read, dmem_write, mem_stall, misalign;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        memwb_valid, memwb_br_en;
  logic [31:0] memwb_instruction, memwb_alu_out, memwb_pc, memwb_rdata;
  logic [7:0]  memwb_ctrl_word;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        br;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .exmem_valid(exmem_valid), .exmem_instruction(exmem_instruction),
    .exmem_ctrl_word(exmem_ctrl_word), .exmem_alu_out(exmem_alu_out),
    .exmem_br_en(exmem_br_en), .exmem_rs2_out(exmem_rs2_out), .exmem_pc(exmem_pc),
    .ext_stall(ext_stall),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .mem_stall(mem_stall), .misalign(misalign),
    .memwb_valid(memwb_valid), .memwb_instruction(memwb_instruction),
    .memwb_ctrl_word(memwb_ctrl_word), .memwb_alu_out(memwb_alu_out),
    .memwb_br_en(memwb_br_en), .memwb_pc(memwb_pc), .memwb_rdata(memwb_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] pc);
    exmem_valid       = 1'b1;
    exmem_instruction = {17'h0, f3, 5'h0, (rd ? 7'b0000011 : 7'b0100011)};
    exmem_ctrl_word   = {6'h0, wr, rd};
    exmem_alu_out     = addr;
    exmem_rs2_out     = rs2;
    exmem_pc          = pc;
    exmem_br_en       = pc[2];
  endtask

  task automatic push(input logic [31:0] rdata, input logic [31:0] pc,
                      input logic [31:0] addr, input logic mis);
    exp_t e;
    e.rdata = rdata; e.pc = pc; e.alu = addr; e.br = pc[2]; e.mis = mis;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_valid"}, 32'(memwb_valid), 32'd1);
      chk({tag, "_rdata"}, memwb_rdata, e.rdata);
      chk({tag, "_pc"}, memwb_pc, e.pc);
      chk({tag, "_alu"}, memwb_alu_out, e.alu);
      chk({tag, "_br"}, 32'(memwb_br_en), 32'(e.br));
      chk({tag, "_mis"}, 32'(misalign), 32'(e.mis));
    end
  endtask

  // One complete access: request visible, 'waits' stall cycles, then response.
  task automatic access(input string tag, input logic [2:0] f3, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] pc,
                        input int unsigned waits, input logic [31:0] rdata,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_mbe,
                        input logic [31:0] exp_wdata);
    drive(f3, rd, wr, addr, rs2, pc);
    push(exp_rdata, pc, addr, 1'b0);
    #1;
    chk({tag, "_addr"}, dmem_address, {addr[31:2], 2'b00});
    chk({tag, "_mbe"}, 32'(dmem_mbe), 32'(exp_mbe));
    if (wr) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    for (int i = 0; i < int'(waits); i++) begin
      chk({tag, "_stall"}, 32'(mem_stall), 32'd1);
      chk({tag, "_rd"}, 32'(dmem_read), 32'(rd));
      chk({tag, "_wr"}, 32'(dmem_write), 32'(wr));
      tick();
      chk({tag, "_bubble"}, 32'(memwb_valid), 32'd0);
    end
    dmem_resp  = 1'b1;
    dmem_rdata = rdata;
    #1;
    chk({tag, "_stall_resp"}, 32'(mem_stall), 32'd0);
    tick();
    dmem_resp   = 1'b0;
    exmem_valid = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    // Reset with a live load presented: request must stay low.
    drive(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h4);
    #1;
    chk("rst_dmem_read", 32'(dmem_read), 32'd0);
    tick(); tick();
    chk("rst_valid", 32'(memwb_valid), 32'd0);
    chk("rst_rdata", memwb_rdata, 32'd0);
    chk("rst_pc", memwb_pc, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    exmem_valid = 1'b0;
    rst = 1'b1;
    tick();

    access("lw_wait", 3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 32'h1000, 3, 32'hDEADBEEF,
           32'hDEADBEEF, 4'b1111, 32'h0);
    access("lb", 3'b000, 1'b1, 1'b0, 32'h103, 32'h0, 32'h1004, 0, 32'h80112233,
           32'hFFFFFF80, 4'b1111, 32'h0);
    access("lbu", 3'b100, 1'b1, 1'b0, 32'h103, 32'h0, 32'h1008, 1, 32'h80112233,
           32'h00000080, 4'b1111, 32'h0);
    access("lhu", 3'b101, 1'b1, 1'b0, 32'h102, 32'h0, 32'h100C, 0, 32'h80112233,
           32'h00008011, 4'b1111, 32'h0);
    access("lh", 3'b001, 1'b1, 1'b0, 32'h102, 32'h0, 32'h1010, 0, 32'h80112233,
           32'hFFFF8011, 4'b1111, 32'h0);
    access("lb_lo", 3'b000, 1'b1, 1'b0, 32'h101, 32'h0, 32'h1014, 0, 32'h80114233,
           32'h00000042, 4'b1111, 32'h0);
    access("sb", 3'b000, 1'b0, 1'b1, 32'h201, 32'h000000AB, 32'h1018, 1, 32'h0,
           32'h0, 4'b0010, 32'h0000AB00);
    access("sh", 3'b001, 1'b0, 1'b1, 32'h202, 32'h00001234, 32'h101C, 0, 32'h0,
           32'h0, 4'b1100, 32'h12340000);
    access("sw", 3'b010, 1'b0, 1'b1, 32'h204, 32'hA5A5F00F, 32'h1020, 2, 32'h0,
           32'h0, 4'b1111, 32'hA5A5F00F);

    // Response coincides with ext_stall: captured once, never re-issued.
    drive(3'b010, 1'b1, 1'b0, 32'h104, 32'h0, 32'h1024);
    push(32'hCAFEF00D, 32'h1024, 32'h104, 1'b0);
    #1;
    chk("hold_stall0", 32'(mem_stall), 32'd1);
    tick();
    chk("hold_bubble", 32'(memwb_valid), 32'd0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    ext_stall  = 1'b1;
    tick();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h11111111;
    #1;
    chk("done_no_reissue", 32'(dmem_read), 32'd0);
    chk("done_no_stall", 32'(mem_stall), 32'd0);
    chk("done_hold_valid", 32'(memwb_valid), 32'd0);
    tick();
    chk("done_no_reissue2", 32'(dmem_read), 32'd0);
    chk("done_hold_valid2", 32'(memwb_valid), 32'd0);
    ext_stall = 1'b0;
    tick();
    exmem_valid = 1'b0;
    pop_check("done_release");
    #1;
    chk("after_release_rd", 32'(dmem_read), 32'd0);

    // Misaligned ops: no request, zero-wait completion with zero data.
    drive(3'b010, 1'b0, 1'b1, 32'h101, 32'h12345678, 32'h1028);
    push(32'h0, 32'h1028, 32'h101, TRAP);
    #1;
    chk("sw_mis_write", 32'(dmem_write), 32'd0);
    chk("sw_mis_stall", 32'(mem_stall), 32'd0);
    tick();
    pop_check("sw_mis");
    drive(3'b001, 1'b1, 1'b0, 32'h103, 32'h0, 32'h102C);
    push(32'h0, 32'h102C, 32'h103, TRAP);
    dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("lh_mis_read", 32'(dmem_read), 32'd0);
    tick();
    pop_check("lh_mis");

    // Invalid slot: no request, bubble propagates.
    exmem_valid = 1'b0;
    #1;
    chk("inv_read", 32'(dmem_read), 32'd0);
    tick();
    chk("inv_bubble", 32'(memwb_valid), 32'd0);
    chk("inv_misalign", 32'(misalign), 32'd0);

    // Reset in the middle of an outstanding access.
    drive(3'b010, 1'b1, 1'b0, 32'h300, 32'h0, 32'h1030);
    #1;
    tick();
    chk("rstw_stall", 32'(mem_stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstw_read_now", 32'(dmem_read), 32'd0);
    tick();
    rst = 1'b1;
    exmem_valid = 1'b0;
    #1;
    chk("rstw_valid", 32'(memwb_valid), 32'd0);
    chk("rstw_pc", memwb_pc, 32'd0);
    chk("rstw_alu", memwb_alu_out, 32'd0);
    chk("rstw_rdata", memwb_rdata, 32'd0);
    chk("rstw_instr", memwb_instruction, 32'd0);
    chk("rstw_ctrl", 32'(memwb_ctrl_word), 32'd0);
    access("post_rst_lw", 3'b010, 1'b1, 1'b0, 32'h308, 32'h0, 32'h1034, 0, 32'h0BADF00D,
           32'h0BADF00D, 4'b1111, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
